// File: rtl/sram_pkg.sv
// Shared constants, responder state encoding and the byte-lane mask helper
// used by the SRAM responder and its backing RAM.
package sram_pkg;

    localparam int unsigned SRAM_ADDR_W = 18;
    localparam int unsigned SRAM_DATA_W = 16;
    localparam int unsigned SRAM_LANES  = 2;
    // Wide enough for a read latency of up to 7 cycles.
    localparam int unsigned SRAM_CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RD_WAIT,
        RD_DRIVE,
        WR_HOLD
    } resp_state_t;

    // Active-low pin strobes to an active-high per-lane enable, lane 0 = [7:0].
    function automatic logic [SRAM_LANES-1:0] lane_mask(input logic lb_n, input logic ub_n);
        return {~ub_n, ~lb_n};
    endfunction

endpackage

// File: rtl/sram_resp_mem.sv
// Single-port byte-enabled RAM backing the SRAM responder; synchronous read,
// one write-enable bit per byte lane. Contents are not reset.
module sram_resp_mem
    import sram_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned DATA_W     = SRAM_DATA_W
) (
    input  logic                  clk,
    input  logic                  rd_en,
    input  logic [SRAM_LANES-1:0] wr_be,
    input  logic [DEPTH_LOG2-1:0] addr,
    input  logic [DATA_W-1:0]     wdata,
    output logic [DATA_W-1:0]     rdata
);

    localparam int unsigned LaneW = DATA_W / SRAM_LANES;
    localparam int unsigned Words = 2 ** DEPTH_LOG2;

    logic [DATA_W-1:0] mem [Words];

    always_ff @(posedge clk) begin
        for (int i = 0; i < SRAM_LANES; i++) begin
            if (wr_be[i]) begin
                mem[addr][i*LaneW +: LaneW] <= wdata[i*LaneW +: LaneW];
            end
        end
        if (rd_en) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/sram_responder.sv
// Clocked device-side model of the 256Kx16 asynchronous SRAM pin interface.
// Define SRAM_RESP_CHECK_EN to build the sticky protocol checker driving prot_err.
module sram_responder
    import sram_pkg::*;
#(
    parameter int unsigned ADDR_W     = SRAM_ADDR_W,
    parameter int unsigned DATA_W     = SRAM_DATA_W,
    parameter int unsigned DEPTH_LOG2 = 12,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce_n,
    input  logic              we_n,
    input  logic              oe_n,
    input  logic              lb_n,
    input  logic              ub_n,
    input  logic [ADDR_W-1:0] addr,
    inout  wire  [DATA_W-1:0] data_io,
    output logic              busy,
    output logic [15:0]       wr_cnt,
    output logic [15:0]       rd_cnt,
    output logic              prot_err
);

    localparam int unsigned              LaneW   = DATA_W / SRAM_LANES;
    localparam logic [SRAM_CNT_W-1:0]    LatInit = SRAM_CNT_W'(RD_LAT - 1);

    // Registered pin samples; all decode works on these.
    logic              s_ce_n, s_we_n, s_oe_n, s_lb_n, s_ub_n;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_data;

    resp_state_t       state_q, state_d;
    logic [SRAM_CNT_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] lat_addr_q, lat_addr_d;
    logic [DATA_W-1:0] w_data_q, w_data_d;
    logic              w_lb_n_q, w_lb_n_d;
    logic              w_ub_n_q, w_ub_n_d;
    logic [15:0]       wr_cnt_q, rd_cnt_q;

    logic                  mem_rd;
    logic [SRAM_LANES-1:0] mem_be;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  wr_inc, rd_inc;
    logic                  pulse_low, rd_abort, addr_moved;
    logic [SRAM_LANES-1:0] lane_drv;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_ce_n     <= 1'b1;
            s_we_n     <= 1'b1;
            s_oe_n     <= 1'b1;
            s_lb_n     <= 1'b1;
            s_ub_n     <= 1'b1;
            s_addr     <= '0;
            s_data     <= '0;
            state_q    <= IDLE;
            cnt_q      <= '0;
            lat_addr_q <= '0;
            w_data_q   <= '0;
            w_lb_n_q   <= 1'b1;
            w_ub_n_q   <= 1'b1;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
        end else begin
            s_ce_n     <= ce_n;
            s_we_n     <= we_n;
            s_oe_n     <= oe_n;
            s_lb_n     <= lb_n;
            s_ub_n     <= ub_n;
            s_addr     <= addr;
            s_data     <= data_io;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            lat_addr_q <= lat_addr_d;
            w_data_q   <= w_data_d;
            w_lb_n_q   <= w_lb_n_d;
            w_ub_n_q   <= w_ub_n_d;
            if (wr_inc) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
            if (rd_inc) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
        end
    end

    assign pulse_low  = !s_ce_n && !s_we_n;
    assign rd_abort   = s_ce_n || s_oe_n || !s_we_n;
    assign addr_moved = s_addr != lat_addr_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        lat_addr_d = lat_addr_q;
        w_data_d   = w_data_q;
        w_lb_n_d   = w_lb_n_q;
        w_ub_n_d   = w_ub_n_q;
        mem_rd     = 1'b0;
        mem_be     = '0;
        wr_inc     = 1'b0;
        rd_inc     = 1'b0;

        unique case (state_q)
            IDLE: begin
                // Write wins over a simultaneous output enable.
                if (pulse_low) begin
                    state_d    = WR_HOLD;
                    lat_addr_d = s_addr;
                    w_data_d   = s_data;
                    w_lb_n_d   = s_lb_n;
                    w_ub_n_d   = s_ub_n;
                end else if (!s_ce_n && !s_oe_n) begin
                    state_d    = RD_WAIT;
                    cnt_d      = LatInit;
                    lat_addr_d = s_addr;
                end
            end
            RD_WAIT, RD_DRIVE: begin
                if (rd_abort) begin
                    state_d = IDLE;
                end else if (addr_moved) begin
                    state_d    = RD_WAIT;
                    cnt_d      = LatInit;
                    lat_addr_d = s_addr;
                end else if (state_q == RD_WAIT) begin
                    if (cnt_q == '0) begin
                        state_d = RD_DRIVE;
                        mem_rd  = 1'b1;
                        rd_inc  = 1'b1;
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            WR_HOLD: begin
                if (pulse_low) begin
                    lat_addr_d = s_addr;
                    w_data_d   = s_data;
                    w_lb_n_d   = s_lb_n;
                    w_ub_n_d   = s_ub_n;
                end else begin
                    // Trailing edge of the pulse: commit what was held while it was low.
                    mem_be  = lane_mask(w_lb_n_q, w_ub_n_q);
                    wr_inc  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    sram_resp_mem #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .DATA_W     (DATA_W)
    ) u_mem (
        .clk   (clk),
        .rd_en (mem_rd),
        .wr_be (mem_be),
        .addr  (lat_addr_q[DEPTH_LOG2-1:0]),
        .wdata (w_data_q),
        .rdata (mem_rdata)
    );

    // Drive comes straight off the state register so reset releases the bus at once.
    assign lane_drv = (state_q == RD_DRIVE) ? lane_mask(s_lb_n, s_ub_n) : '0;

    for (genvar g = 0; g < SRAM_LANES; g++) begin : g_lane
        assign data_io[g*LaneW +: LaneW] = lane_drv[g] ? mem_rdata[g*LaneW +: LaneW]
                                                       : {LaneW{1'bz}};
    end

    assign busy   = state_q != IDLE;
    assign wr_cnt = wr_cnt_q;
    assign rd_cnt = rd_cnt_q;

`ifdef SRAM_RESP_CHECK_EN
    logic err_q, err_set, long_q;

    always_comb begin
        err_set = !s_ce_n && !s_we_n && !s_oe_n;
        if (state_q == WR_HOLD) begin
            if (pulse_low) begin
                if (addr_moved || (s_lb_n != w_lb_n_q) || (s_ub_n != w_ub_n_q)) begin
                    err_set = 1'b1;
                end
            end else if (!long_q) begin
                err_set = 1'b1;
            end
        end
    end

    // long_q marks a write pulse that has been sampled low on at least two cycles.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q  <= 1'b0;
            long_q <= 1'b0;
        end else begin
            long_q <= (state_q == WR_HOLD) && pulse_low;
            if (err_set) begin
                err_q <= 1'b1;
            end
        end
    end

    assign prot_err = err_q;
`else
    assign prot_err = 1'b0;
`endif

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder: a table of write/read vectors plus
// hand-written sequences for address change, read-after-write, reset and contention.
module tb_sram_responder;

    logic        clk;
    logic        rst;
    logic        ce_n, we_n, oe_n, lb_n, ub_n;
    logic [17:0] addr;
    logic [15:0] data_tb;
    logic        tb_oe;
    // Pulled low so a released lane reads back as 0 on a two-state simulator too.
    tri0  [15:0] data_io;
    logic        busy;
    logic [15:0] wr_cnt, rd_cnt;
    logic        prot_err;

    int n_tests;
    int n_fail;
    int wr_exp;
    int rd_exp;

    assign data_io = tb_oe ? data_tb : 16'hzzzz;

    sram_responder #(
        .ADDR_W     (18),
        .DATA_W     (16),
        .DEPTH_LOG2 (12),
        .RD_LAT     (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .ce_n     (ce_n),
        .we_n     (we_n),
        .oe_n     (oe_n),
        .lb_n     (lb_n),
        .ub_n     (ub_n),
        .addr     (addr),
        .data_io  (data_io),
        .busy     (busy),
        .wr_cnt   (wr_cnt),
        .rd_cnt   (rd_cnt),
        .prot_err (prot_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        do_wr;
        logic [17:0] waddr;
        logic [15:0] wdata;
        logic        wlb_n;
        logic        wub_n;
        logic [17:0] raddr;
        logic        rlb_n;
        logic        rub_n;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // All stimulus tasks start right after a negedge and return on one.
    task automatic wr_pulse(input logic [17:0] a, input logic [15:0] d, input logic l,
                            input logic u);
        addr = a; data_tb = d; tb_oe = 1'b1; lb_n = l; ub_n = u;
        ce_n = 1'b0; we_n = 1'b0;
        repeat (2) @(negedge clk);
        we_n = 1'b1; ce_n = 1'b1; tb_oe = 1'b0;
        repeat (3) @(negedge clk);
        wr_exp++;
    endtask

    task automatic rd_start(input logic [17:0] a, input logic l, input logic u);
        addr = a; lb_n = l; ub_n = u;
        ce_n = 1'b0; oe_n = 1'b0; we_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic rd_end();
        oe_n = 1'b1; ce_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0; n_fail = 0; wr_exp = 0; rd_exp = 0;
        rst = 1'b0; ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; lb_n = 1'b1; ub_n = 1'b1;
        addr = '0; data_tb = '0; tb_oe = 1'b0;

        //             wr    waddr      wdata    wlb   wub   raddr      rlb   rub   expect
        vecs[0] = '{1'b1, 18'h00010, 16'hA55A, 1'b0, 1'b0, 18'h00010, 1'b0, 1'b0, 16'hA55A};
        vecs[1] = '{1'b1, 18'h00020, 16'h1234, 1'b0, 1'b0, 18'h00020, 1'b0, 1'b0, 16'h1234};
        vecs[2] = '{1'b1, 18'h00020, 16'hFFFF, 1'b0, 1'b1, 18'h00020, 1'b0, 1'b0, 16'h12FF};
        vecs[3] = '{1'b0, 18'h00000, 16'h0000, 1'b1, 1'b1, 18'h00020, 1'b1, 1'b0, 16'h1200};
        vecs[4] = '{1'b1, 18'h01000, 16'hBEEF, 1'b0, 1'b0, 18'h00000, 1'b0, 1'b0, 16'hBEEF};
        vecs[5] = '{1'b1, 18'h00020, 16'h0000, 1'b1, 1'b1, 18'h00020, 1'b0, 1'b0, 16'h12FF};
        vecs[6] = '{1'b1, 18'h00FFF, 16'hC3C3, 1'b0, 1'b0, 18'h3FFFF, 1'b0, 1'b0, 16'hC3C3};
        vecs[7] = '{1'b0, 18'h00000, 16'h0000, 1'b1, 1'b1, 18'h00010, 1'b0, 1'b1, 16'h005A};

        repeat (3) @(negedge clk);
        check("reset busy", {15'd0, busy}, 16'd0);
        check("reset wr_cnt", wr_cnt, 16'd0);
        check("reset rd_cnt", rd_cnt, 16'd0);
        check("reset prot_err", {15'd0, prot_err}, 16'd0);
        check("reset bus", data_io, 16'h0000);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            if (vecs[i].do_wr) begin
                wr_pulse(vecs[i].waddr, vecs[i].wdata, vecs[i].wlb_n, vecs[i].wub_n);
                check($sformatf("vec%0d wr_cnt", i), wr_cnt, 16'(wr_exp));
            end
            rd_start(vecs[i].raddr, vecs[i].rlb_n, vecs[i].rub_n);
            check($sformatf("vec%0d bus before latency", i), data_io, 16'h0000);
            @(negedge clk);
            check($sformatf("vec%0d read data", i), data_io, vecs[i].exp);
            rd_exp++;
            check($sformatf("vec%0d rd_cnt", i), rd_cnt, 16'(rd_exp));
            rd_end();
        end

        // Address moves 5 -> 6 while the bus is being driven.
        wr_pulse(18'h00005, 16'h0005, 1'b0, 1'b0);
        wr_pulse(18'h00006, 16'h0006, 1'b0, 1'b0);
        rd_start(18'h00005, 1'b0, 1'b0);
        @(negedge clk);
        check("addr chg first data", data_io, 16'h0005);
        addr = 18'h00006;
        @(negedge clk);
        check("addr chg still old", data_io, 16'h0005);
        @(negedge clk);
        check("addr chg released", data_io, 16'h0000);
        check("addr chg busy", {15'd0, busy}, 16'd1);
        @(negedge clk);
        check("addr chg new data", data_io, 16'h0006);
        rd_exp += 2;
        check("addr chg rd_cnt", rd_cnt, 16'(rd_exp));
        rd_end();

        // Read requested on the same sample as the write pulse rises.
        addr = 18'h00050; data_tb = 16'hAAAA; tb_oe = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
        ce_n = 1'b0; we_n = 1'b0;
        repeat (2) @(negedge clk);
        we_n = 1'b1; oe_n = 1'b0; tb_oe = 1'b0;
        repeat (4) @(negedge clk);
        check("raw data", data_io, 16'hAAAA);
        wr_exp++; rd_exp++;
        check("raw wr_cnt", wr_cnt, 16'(wr_exp));
        check("raw rd_cnt", rd_cnt, 16'(rd_exp));
        rd_end();

        // Reset while driving read data.
        rd_start(18'h00010, 1'b0, 1'b0);
        @(negedge clk);
        check("pre-reset read", data_io, 16'hA55A);
        #2 rst = 1'b0;
        #1;
        check("reset mid-read bus", data_io, 16'h0000);
        check("reset mid-read busy", {15'd0, busy}, 16'd0);
        oe_n = 1'b1; ce_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wr_exp = 0; rd_exp = 0;
        @(negedge clk);

        // Reset in the middle of a write pulse discards it.
        wr_pulse(18'h00040, 16'h1111, 1'b0, 1'b0);
        addr = 18'h00040; data_tb = 16'h9999; tb_oe = 1'b1; lb_n = 1'b0; ub_n = 1'b0;
        ce_n = 1'b0; we_n = 1'b0;
        repeat (3) @(negedge clk);
        check("mid-write busy", {15'd0, busy}, 16'd1);
        #2 rst = 1'b0; tb_oe = 1'b0;
        #1;
        check("reset mid-write busy", {15'd0, busy}, 16'd0);
        check("reset mid-write wr_cnt", wr_cnt, 16'd0);
        check("reset mid-write bus", data_io, 16'h0000);
        ce_n = 1'b1; we_n = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        wr_exp = 0; rd_exp = 0;
        @(negedge clk);
        rd_start(18'h00040, 1'b0, 1'b0);
        @(negedge clk);
        check("discarded write", data_io, 16'h1111);
        rd_exp++;
        check("post-reset rd_cnt", rd_cnt, 16'(rd_exp));
        rd_end();

        // One-cycle ce/we/oe all low: write wins, nothing is driven.
        addr = 18'h00077; lb_n = 1'b0; ub_n = 1'b0;
        ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0;
        @(negedge clk);
        ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1;
        check("contention bus 1", data_io, 16'h0000);
        @(negedge clk);
        check("contention bus 2", data_io, 16'h0000);
`ifdef SRAM_RESP_CHECK_EN
        check("prot_err set", {15'd0, prot_err}, 16'd1);
`else
        check("prot_err tied", {15'd0, prot_err}, 16'd0);
`endif
        repeat (4) @(negedge clk);
        wr_exp++;
        check("contention wr_cnt", wr_cnt, 16'(wr_exp));
`ifdef SRAM_RESP_CHECK_EN
        check("prot_err sticky", {15'd0, prot_err}, 16'd1);
`else
        check("prot_err still 0", {15'd0, prot_err}, 16'd0);
`endif
        check("final busy", {15'd0, busy}, 16'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
